countdown_timer: RTL



---
 rtl/countdown_timer.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/countdown_timer.sv
// countdown_timer
//
// Down-counting MM:SS timer with BCD time registers. A clock-cycle prescaler
// produces the one-second tick. The timer flags expiry with a one-cycle done
// pulse and a sticky alarm.
//
// Optional feature (compile-time macro): COUNTDOWN_AUTO_RELOAD_EN
//   When defined, the timer reloads the last loaded value at expiry and keeps
//   running. When undefined, it holds 00:00 in EXPIRED until the next load.
//
// Parameters:
//   TICK_DIV  clock cycles per one-second decrement (minimum 2)
//   PRE_W     prescaler width, 2**PRE_W >= TICK_DIV
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-low reset
//   load      load load_min/load_sec (clamped to valid BCD time)
//   load_min  BCD minutes, tens [7:4], ones [3:0]
//   load_sec  BCD seconds, tens [7:4], ones [3:0]
//   start     begin or resume the countdown
//   stop      pause the countdown
//   ack       clear the alarm
//   min, sec  current BCD time
//   running   high while counting
//   done      one-cycle pulse on expiry
//   alarm     sticky expiry flag
module countdown_timer #(
    parameter int TICK_DIV = 10,
    parameter int PRE_W    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_min,
    input  logic [7:0] load_sec,
    input  logic       start,
    input  logic       stop,
    input  logic       ack,
    output logic [7:0] min,
    output logic [7:0] sec,
    output logic       running,
    output logic       done,
    output logic       alarm
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    localparam logic [PRE_W-1:0] LAST_PRE = PRE_W'(TICK_DIV - 1);

    state_t           r_state;
    logic [PRE_W-1:0] r_pre;
    logic [7:0]       r_min;
    logic [7:0]       r_sec;
    logic             r_done;
    logic             r_alarm;

    logic [7:0]       w_loadMin;
    logic [7:0]       w_loadSec;
    logic [7:0]       w_decMin;
    logic [7:0]       w_decSec;
    logic             w_timeZero;
    logic             w_decZero;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [7:0]       r_reloadMin;
    logic [7:0]       r_reloadSec;
    logic             w_reloadZero;

    assign w_reloadZero = (r_reloadMin == 8'h00) && (r_reloadSec == 8'h00);
`endif

    function automatic logic [3:0] clampDigit(input logic [3:0] d, input logic [3:0] lim);
        return (d > lim) ? lim : d;
    endfunction

    assign w_loadMin = {clampDigit(load_min[7:4], 4'd9), clampDigit(load_min[3:0], 4'd9)};
    assign w_loadSec = {clampDigit(load_sec[7:4], 4'd5), clampDigit(load_sec[3:0], 4'd9)};

    assign w_timeZero = (r_min == 8'h00) && (r_sec == 8'h00);

    // One-second BCD decrement with borrow ripple sec ones -> sec tens ->
    // min ones -> min tens. Only used when the time is non-zero, so the
    // minutes tens digit never underflows.
    always_comb begin
        w_decMin = r_min;
        w_decSec = r_sec;
        if (r_sec[3:0] != 4'd0) begin
            w_decSec[3:0] = r_sec[3:0] - 4'd1;
        end else begin
            w_decSec[3:0] = 4'd9;
            if (r_sec[7:4] != 4'd0) begin
                w_decSec[7:4] = r_sec[7:4] - 4'd1;
            end else begin
                w_decSec[7:4] = 4'd5;
                if (r_min[3:0] != 4'd0) begin
                    w_decMin[3:0] = r_min[3:0] - 4'd1;
                end else begin
                    w_decMin[3:0] = 4'd9;
                    w_decMin[7:4] = r_min[7:4] - 4'd1;
                end
            end
        end
    end

    assign w_decZero = (w_decMin == 8'h00) && (w_decSec == 8'h00);

    // Control FSM and datapath. Priority is load > stop > start; ack is
    // applied first so that an expiry on the same edge overrides it.
    // stop on the final tick wins because the tick branch is never reached.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_pre   <= '0;
            r_min   <= 8'h00;
            r_sec   <= 8'h00;
            r_done  <= 1'b0;
            r_alarm <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            r_reloadMin <= 8'h00;
            r_reloadSec <= 8'h00;
`endif
        end else begin
            r_done <= 1'b0;
            if (ack) begin
                r_alarm <= 1'b0;
            end

            if (load) begin
                r_min   <= w_loadMin;
                r_sec   <= w_loadSec;
                r_pre   <= '0;
                r_state <= ST_IDLE;
                r_alarm <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                r_reloadMin <= w_loadMin;
                r_reloadSec <= w_loadSec;
`endif
            end else if (stop) begin
                if (r_state == ST_RUN) begin
                    r_state <= ST_PAUSE;
                end
            end else if (start && (r_state == ST_IDLE || r_state == ST_PAUSE)) begin
                // Prescaler is left alone so a resume continues the
                // partially elapsed second.
                if (!w_timeZero) begin
                    r_state <= ST_RUN;
                end
            end else if (r_state == ST_RUN) begin
                if (r_pre == LAST_PRE) begin
                    r_pre <= '0;
                    if (!w_timeZero) begin
                        if (w_decZero) begin
                            r_done  <= 1'b1;
                            r_alarm <= 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                            if (!w_reloadZero) begin
                                r_min <= r_reloadMin;
                                r_sec <= r_reloadSec;
                            end else begin
                                r_min   <= 8'h00;
                                r_sec   <= 8'h00;
                                r_state <= ST_EXPIRED;
                            end
`else
                            r_min   <= 8'h00;
                            r_sec   <= 8'h00;
                            r_state <= ST_EXPIRED;
`endif
                        end else begin
                            r_min <= w_decMin;
                            r_sec <= w_decSec;
                        end
                    end
                end else begin
                    r_pre <= r_pre + PRE_W'(1);
                end
            end
        end
    end

    assign min     = r_min;
    assign sec     = r_sec;
    assign running = (r_state == ST_RUN);
    assign done    = r_done;
    assign alarm   = r_alarm;

endmodule
